led_row_scan_ctrl: RTL and testbench
====================================

# led_row_scan_ctrl

Row-scan controller for the screen-leds matrix. It holds a frame of up to 8 row bytes written by the edit path: the button counter supplies `wr_row` and `wr_data`, and a commit pulse drives `wr_en`. It time-multiplexes those bytes onto the shared column drivers one row at a time, with a blanking gap between rows to suppress ghosting. It sits between the edit/counter logic and the LED pins, and is the only block that drives the column and row-select lines.

## Interface
- `ROWS`, default 6: number of rows in the stack; legal range 1..8.
- `SCAN_DIV`, default 1024: clock cycles each row is lit (SHOW dwell); must be ≥1.
- `BLANK`, default 16: clock cycles all rows are off between rows; must be ≥1.
- `clk`  in  1: system clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: write request, sampled every cycle.
- `wr_row`  in  3: target row index for the write.
- `wr_data`  in  8: byte to store.
- `wr_ack`  out  1: 1-cycle pulse, the write was accepted.
- `wr_err`  out  1: 1-cycle pulse, the write was rejected because `wr_row` ≥ `ROWS`.
- `cols`  out  8: column drive for the lit row.
- `row_sel`  out  `ROWS`: one-hot row enable.
- `row_idx`  out  3: index of the current or next row.
- `frame_tick`  out  1: 1-cycle pulse at frame wrap.

## Operation
- Frame buffer: `ROWS` × 8-bit registers, all cleared by reset.
- Write acceptance:
  - `wr_en`=1 with `wr_row` < `ROWS`: store `wr_data` at that row on this edge; `wr_ack`=1 next cycle.
  - `wr_en`=1 with `wr_row` ≥ `ROWS`: buffer unchanged; `wr_err`=1 next cycle.
  - A write is accepted every cycle; there is no backpressure.
- FSM states: BLANK, SHOW.
- BLANK:
  - `row_sel`=0 and `cols`=0.
  - Dwell counter counts up to `BLANK`-1.
  - On the terminal count: latch `buffer[row_idx]` into `cols`, drive `row_sel` = 1<<`row_idx`, clear the counter, go to SHOW.
- SHOW:
  - `cols` and `row_sel` hold their latched values for `SCAN_DIV` cycles.
  - On the terminal count: go to BLANK, clear the counter, advance `row_idx`.
  - Row wrap: `ROWS`-1 → 0. On that transition `frame_tick`=1 for one cycle.
- Tear-free display: a write to the row currently in SHOW does not change `cols` until that row's next visit.
- Simultaneous write and latch to the same row in the same cycle: write-through bypass, so `cols` takes `wr_data`.
- Writes to other rows never disturb the current SHOW.
- Dwell counter width is clog2(max(`SCAN_DIV`,`BLANK`)). Comparisons are against parameter-1; no overflow is possible.
- `row_idx` increments modulo `ROWS`, never by 3-bit natural wrap. With `ROWS`=6 the sequence is 0..5,0.

## Timing
- Reset values: `cols`=0, `row_sel`=0, `row_idx`=0, `wr_ack`=0, `wr_err`=0, `frame_tick`=0; state BLANK; counter 0; buffer all 0.
- Reset mid-operation: on the first edge with `rst`=1, all of the above apply regardless of state. A `wr_en` in a reset cycle is dropped, with no ack.
- After `rst` falls, row 0 lights at cycle `BLANK` (cycle 0 is the first cycle out of reset).
- Row k lights at `BLANK` + k·(`BLANK`+`SCAN_DIV`).
- Frame period is `ROWS`·(`BLANK`+`SCAN_DIV`) cycles.
- `frame_tick` asserts in the first BLANK cycle of row 0 of each new frame. It does not assert after reset.
- Write latency: ack/err one cycle after `wr_en`. The data is visible on `cols` at the next BLANK→SHOW of that row.
- `cols` and `row_sel` are registered outputs and change only at state transitions.

## Structure
- Package `screen_pkg`:
  - state enum {BLANK, SHOW}
  - `ROW_W`=3, `BYTE_W`=8
  - function for the modulo-`ROWS` increment
- Sub-module `row_buffer`:
  - `ROWS`×8 register file
  - one synchronous write port
  - one combinational read port with the write-through bypass
- The FSM, dwell counter and output registers live in the top module.

## Test plan
- `ROWS`=6, `SCAN_DIV`=4, `BLANK`=2, reset, no writes:
  - `row_sel` sequence is 0,0 then 000001×4, 0,0, 000010×4 … 100000×4, then 0 with `frame_tick` pulse.
  - Period is 36 cycles; `cols`=0 throughout.
- Write row 3=0xA5 and row 0=0x3C in consecutive cycles:
  - `wr_ack` pulses on both.
  - Next frame shows `cols`=0x3C with `row_sel`=000001, and 0xA5 with `row_sel`=001000.
- Write row 2=0xFF during SHOW of row 2: `cols` stays 0 for the rest of the dwell, then 0xFF on the next frame's row 2.
- Write row 1=0x81 in the exact cycle BLANK→SHOW latches row 1: `cols`=0x81 immediately (bypass).
- Write with `wr_row`=6 and `wr_row`=7 (data 0xFF): `wr_err` pulses and no `wr_ack`; a full frame of `cols` shows unchanged buffer contents.
- Assert `rst` for 1 cycle mid-SHOW of row 4 after loading 0x11..0x66:
  - All outputs go to 0 and the buffer clears.
  - Row 0 relights after 2 cycles with `cols`=0.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared types and helpers for the LED row-scan controller.
//   - scan_state_e : blanking / showing phase of the row scan
//   - ROW_W, BYTE_W: row-index and column-byte widths
//   - row_inc()    : row index increment that wraps at the configured row count
package screen_pkg;

  localparam int unsigned ROW_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [0:0] {
    StBlank,
    StShow
  } scan_state_e;

  // Wraps at rows-1 rather than at the natural 3-bit boundary.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] idx,
                                               input int unsigned      rows);
    if (32'(idx) + 32'd1 >= rows) begin
      return '0;
    end
    return idx + ROW_W'(1);
  endfunction

endpackage

// File: rtl/row_buffer.sv
// Frame buffer of ROWS column bytes.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset (clears every row)
//   i_wr_en       : write strobe; rows at or above ROWS match no entry and are ignored
//   i_wr_row      : write row index
//   i_wr_data     : write byte
//   i_rd_row      : read row index
//   o_rd_data     : read byte, with write-through when writing the row being read
module row_buffer
  import screen_pkg::*;
#(
  parameter int unsigned ROWS = 6
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ROW_W-1:0]  i_wr_row,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic [ROW_W-1:0]  i_rd_row,
  output logic [BYTE_W-1:0] o_rd_data
);

  logic [BYTE_W-1:0] r_mem [ROWS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      for (int i = 0; i < int'(ROWS); i++) begin
        if (i_wr_row == ROW_W'(i)) begin
          r_mem[i] <= i_wr_data;
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int i = 0; i < int'(ROWS); i++) begin
      if (i_rd_row == ROW_W'(i)) begin
        o_rd_data = r_mem[i];
      end
    end
    // Bypass so a row latched in the same cycle it is written shows the new byte.
    if (i_wr_en && (i_wr_row == i_rd_row)) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule

// File: rtl/led_row_scan_ctrl.sv
// Row-scan controller: time-multiplexes a frame of row bytes onto shared column drivers,
// with a blanking gap between rows to suppress ghosting.
// Ports:
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_wr_en/_row/_data     : frame buffer write request
//   o_wr_ack, o_wr_err     : 1-cycle accept / reject (row >= ROWS) pulse after a write
//   o_cols                 : column byte of the lit row (0 while blanking)
//   o_row_sel              : one-hot row enable (0 while blanking)
//   o_row_idx              : current (or next, while blanking) row index
//   o_frame_tick           : 1-cycle pulse on the first blank cycle of each new frame
module led_row_scan_ctrl
  import screen_pkg::*;
#(
  parameter int unsigned ROWS     = 6,
  parameter int unsigned SCAN_DIV = 1024,
  parameter int unsigned BLANK    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_en,
  input  logic [ROW_W-1:0]  i_wr_row,
  input  logic [BYTE_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  output logic              o_wr_err,
  output logic [BYTE_W-1:0] o_cols,
  output logic [ROWS-1:0]   o_row_sel,
  output logic [ROW_W-1:0]  o_row_idx,
  output logic              o_frame_tick
);

  localparam int unsigned DwellMax  = (SCAN_DIV > BLANK) ? SCAN_DIV : BLANK;
  localparam int unsigned CntW      = (DwellMax > 1) ? $clog2(DwellMax) : 1;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK - 1);
  localparam logic [CntW-1:0] ShowLast  = CntW'(SCAN_DIV - 1);

  scan_state_e       r_state;
  logic [CntW-1:0]   r_cnt;
  logic [ROW_W-1:0]  r_row_idx;
  logic [BYTE_W-1:0] r_cols;
  logic [ROWS-1:0]   r_row_sel;
  logic              r_wr_ack;
  logic              r_wr_err;
  logic              r_frame_tick;

  logic              w_wr_valid;
  logic [BYTE_W-1:0] w_rd_data;

  assign w_wr_valid = i_wr_en && (32'(i_wr_row) < ROWS);

  row_buffer #(
    .ROWS(ROWS)
  ) u_row_buffer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_wr_valid),
    .i_wr_row  (i_wr_row),
    .i_wr_data (i_wr_data),
    .i_rd_row  (r_row_idx),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StBlank;
      r_cnt        <= '0;
      r_row_idx    <= '0;
      r_cols       <= '0;
      r_row_sel    <= '0;
      r_wr_ack     <= 1'b0;
      r_wr_err     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_wr_ack     <= w_wr_valid;
      r_wr_err     <= i_wr_en && !w_wr_valid;
      r_frame_tick <= 1'b0;
      case (r_state)
        StBlank: begin
          if (r_cnt == BlankLast) begin
            r_cols    <= w_rd_data;
            r_row_sel <= ROWS'(1) << r_row_idx;
            r_cnt     <= '0;
            r_state   <= StShow;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StShow: begin
          if (r_cnt == ShowLast) begin
            r_cols       <= '0;
            r_row_sel    <= '0;
            r_cnt        <= '0;
            r_state      <= StBlank;
            r_row_idx    <= row_inc(r_row_idx, ROWS);
            r_frame_tick <= (32'(r_row_idx) == ROWS - 1);
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        default: r_state <= StBlank;
      endcase
    end
  end

  assign o_wr_ack     = r_wr_ack;
  assign o_wr_err     = r_wr_err;
  assign o_cols       = r_cols;
  assign o_row_sel    = r_row_sel;
  assign o_row_idx    = r_row_idx;
  assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_row_scan_ctrl.sv
// Bench for led_row_scan_ctrl (ROWS=6, SCAN_DIV=4, BLANK=2). The reference model derives
// every output from the cycle count since reset: position in frame -> row slot -> phase.
module tb_led_row_scan_ctrl;

  localparam int ROWS  = 6;
  localparam int SD    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = BL + SD;
  localparam int P     = ROWS * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack, wr_err, frame_tick;
  logic [7:0] cols;
  logic [5:0] row_sel;
  logic [2:0] row_idx;

  led_row_scan_ctrl #(
    .ROWS     (ROWS),
    .SCAN_DIV (SD),
    .BLANK    (BL)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_en      (wr_en),
    .i_wr_row     (wr_row),
    .i_wr_data    (wr_data),
    .o_wr_ack     (wr_ack),
    .o_wr_err     (wr_err),
    .o_cols       (cols),
    .o_row_sel    (row_sel),
    .o_row_idx    (row_idx),
    .o_frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int         n_pass  = 0;
  int         n_total = 0;
  int         t       = 0;   // cycles since reset release
  bit         known   = 0;
  logic [7:0] mbuf [ROWS];
  logic [7:0] shown   = '0;  // byte latched for the current visit
  bit         exp_ack = 0;
  bit         exp_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
  endtask

  // One clock cycle: apply inputs, check this cycle's outputs, advance the model.
  task automatic step(input bit r, input bit en, input logic [2:0] row, input logic [7:0] d);
    int p, slot, ph;
    bit lit;
    rst = r; wr_en = en; wr_row = row; wr_data = d;
    p    = t % P;
    slot = p / SLOT;
    ph   = p % SLOT;
    lit  = (ph >= BL);
    #1;
    if (known) begin
      check_val("row_sel", 32'(row_sel), lit ? (32'd1 << slot) : 32'd0);
      check_val("cols", 32'(cols), lit ? 32'(shown) : 32'd0);
      check_val("row_idx", 32'(row_idx), 32'(slot));
      check_val("frame_tick", 32'(frame_tick), (p == 0 && t >= P) ? 32'd1 : 32'd0);
      check_val("wr_ack", 32'(wr_ack), 32'(exp_ack));
      check_val("wr_err", 32'(wr_err), 32'(exp_err));
    end
    @(posedge clk);
    if (r) begin
      known = 1; t = 0; shown = '0; exp_ack = 0; exp_err = 0;
      for (int i = 0; i < ROWS; i++) mbuf[i] = '0;
    end else if (known) begin
      exp_ack = en && (int'(row) < ROWS);
      exp_err = en && (int'(row) >= ROWS);
      if (exp_ack) mbuf[row] = d;
      if (ph == BL - 1) shown = mbuf[slot];
      t++;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 3'd0, 8'd0);
  endtask

  // Idle until the frame position reaches pos (at most one frame).
  task automatic idle_until(input int pos);
    for (int i = 0; i < P && (t % P) != pos; i++) step(0, 0, 3'd0, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    step(1, 0, 3'd0, 8'd0);
    step(1, 0, 3'd0, 8'd0);
    // Plain scan, one frame plus the wrap.
    idle(P + 4);
    // Two back-to-back writes, then two frames to see them.
    step(0, 1, 3'd3, 8'hA5);
    step(0, 1, 3'd0, 8'h3C);
    idle(2 * P);
    // Write row 2 during its own SHOW: must not tear.
    idle_until(2 * SLOT + BL + 1);
    step(0, 1, 3'd2, 8'hFF);
    idle(P + 4);
    // Write row 1 exactly at its latch cycle: bypass.
    idle_until(SLOT + BL - 1);
    step(0, 1, 3'd1, 8'h81);
    idle(3);
    // Out-of-range writes.
    step(0, 1, 3'd6, 8'hFF);
    step(0, 1, 3'd7, 8'hFF);
    idle(P + 2);
    // Load 0x11..0x66 then reset mid-SHOW of row 4, with a write in the reset cycle.
    for (int i = 0; i < ROWS; i++) step(0, 1, 3'(i), 8'(8'h11 * (i + 1)));
    idle(P);
    idle_until(4 * SLOT + BL + 1);
    step(1, 1, 3'd2, 8'h5A);
    idle(P + 4);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      step(($urandom % 200) == 0, ($urandom % 3) == 0, 3'($urandom), 8'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
